// File: rtl/sram_mq_fifo_ctrl.sv
// Multi-queue FIFO controller: NUM_QUEUES circular queues in one SRAM space, with credit-limited
// reads and an in-order tagged return buffer. Define SRAM_MQ_STATS_EN for per-queue high-water marks.
module sram_mq_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH      = 265,
  parameter int unsigned NUM_QUEUES      = 4,
  parameter int unsigned QID_WIDTH       = 2,
  parameter int unsigned QDEPTH_BITS     = 17,
  parameter int unsigned ADDR_WIDTH      = 19,
  parameter int unsigned AFULL_MARGIN    = 8,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_valid,
  input  logic [QID_WIDTH-1:0]                  wr_qid,
  input  logic [DATA_WIDTH-1:0]                 wr_data,
  output logic                                  wr_ready,
  input  logic                                  rd_req_valid,
  input  logic [QID_WIDTH-1:0]                  rd_req_qid,
  output logic                                  rd_req_ready,
  output logic                                  rd_valid,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic [QID_WIDTH-1:0]                  rd_qid,
  input  logic                                  rd_ready,
  output logic [NUM_QUEUES-1:0]                 q_empty,
  output logic [NUM_QUEUES-1:0]                 q_afull,
  output logic                                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                 mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wr_data,
  input  logic                                  mem_wr_full,
  output logic                                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                 mem_rd_addr,
  input  logic                                  mem_rd_full,
  input  logic [DATA_WIDTH-1:0]                 mem_rd_data,
  input  logic                                  mem_rd_valid,
  output logic [NUM_QUEUES*(QDEPTH_BITS+1)-1:0] stat_hwm
);

  localparam int unsigned CNT_W = QDEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = {1'b1, {QDEPTH_BITS{1'b0}}};
  localparam logic [CNT_W-1:0] AFULL_LIM =
    ((AFULL_MARGIN >> QDEPTH_BITS) != 0) ? FULL_CNT : CNT_W'(AFULL_MARGIN);
  localparam int unsigned OB_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OC_W = $clog2(MAX_OUTSTANDING) + 2;

  if (ADDR_WIDTH != QID_WIDTH + QDEPTH_BITS) begin : g_addr_chk
    $error("ADDR_WIDTH must equal QID_WIDTH + QDEPTH_BITS");
  end
  if ((MAX_OUTSTANDING < 2) || ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0)) begin : g_out_chk
    $error("MAX_OUTSTANDING must be a power of 2, at least 2");
  end

  logic [QDEPTH_BITS-1:0] wptr_q  [NUM_QUEUES];
  logic [QDEPTH_BITS-1:0] wptr_d  [NUM_QUEUES];
  logic [QDEPTH_BITS-1:0] rptr_q  [NUM_QUEUES];
  logic [QDEPTH_BITS-1:0] rptr_d  [NUM_QUEUES];
  logic [CNT_W-1:0]       count_q [NUM_QUEUES];
  logic [CNT_W-1:0]       count_d [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]  q_empty_q, q_empty_d, q_afull_q, q_afull_d;
  logic [NUM_QUEUES-1:0]  wr_hit, rd_hit;

  logic                   mem_wr_en_q, mem_wr_en_d, mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_WIDTH-1:0]  mem_wr_addr_q, mem_wr_addr_d, mem_rd_addr_q, mem_rd_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wr_data_q, mem_wr_data_d;

  logic [QID_WIDTH-1:0]   tag_qid_q  [MAX_OUTSTANDING];
  logic [QID_WIDTH-1:0]   tag_qid_d  [MAX_OUTSTANDING];
  logic [OB_W-1:0]        tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;
  logic [OC_W-1:0]        tag_cnt_q, tag_cnt_d;

  logic [DATA_WIDTH-1:0]  ret_data_q [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0]  ret_data_d [MAX_OUTSTANDING];
  logic [QID_WIDTH-1:0]   ret_qid_q  [MAX_OUTSTANDING];
  logic [QID_WIDTH-1:0]   ret_qid_d  [MAX_OUTSTANDING];
  logic [OB_W-1:0]        ret_wptr_q, ret_wptr_d, ret_rptr_q, ret_rptr_d;
  logic [OC_W-1:0]        ret_cnt_q, ret_cnt_d;

  logic wr_fire, rd_fire, tag_pop, ret_push, ret_pop;
  logic [OC_W-1:0] credits_used;

  // Handshakes. A pop this cycle frees its credit for a request in the same cycle.
  always_comb begin
    wr_ready     = !mem_wr_full && (32'(wr_qid) < NUM_QUEUES) && (count_q[wr_qid] != FULL_CNT);
    credits_used = tag_cnt_q + ret_cnt_q - OC_W'(ret_pop);
    rd_req_ready = !mem_rd_full && (32'(rd_req_qid) < NUM_QUEUES) &&
                   (count_q[rd_req_qid] != '0) && (credits_used < OC_W'(MAX_OUTSTANDING));
    wr_fire      = wr_valid && wr_ready;
    rd_fire      = rd_req_valid && rd_req_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      wr_hit[i]  = wr_fire && (wr_qid == QID_WIDTH'(i));
      rd_hit[i]  = rd_fire && (rd_req_qid == QID_WIDTH'(i));
      wptr_d[i]  = wptr_q[i] + QDEPTH_BITS'(wr_hit[i]);
      rptr_d[i]  = rptr_q[i] + QDEPTH_BITS'(rd_hit[i]);
      count_d[i] = count_q[i];
      if (wr_hit[i] && !rd_hit[i]) begin
        count_d[i] = count_q[i] + CNT_W'(1);
      end else if (rd_hit[i] && !wr_hit[i]) begin
        count_d[i] = count_q[i] - CNT_W'(1);
      end
      q_empty_d[i] = (count_d[i] == '0);
      q_afull_d[i] = ((FULL_CNT - count_d[i]) <= AFULL_LIM);
    end
  end

  // Addresses and data hold their last value while the strobe is low.
  always_comb begin
    mem_wr_en_d   = wr_fire;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    mem_rd_en_d   = rd_fire;
    mem_rd_addr_d = mem_rd_addr_q;
    if (wr_fire) begin
      mem_wr_addr_d = {wr_qid, wptr_q[wr_qid]};
      mem_wr_data_d = wr_data;
    end
    if (rd_fire) begin
      mem_rd_addr_d = {rd_req_qid, rptr_q[rd_req_qid]};
    end
  end

  // Responses with nothing outstanding are stale and leave all state untouched.
  assign tag_pop  = mem_rd_valid && (tag_cnt_q != '0);
  assign ret_push = tag_pop;
  assign ret_pop  = rd_valid && rd_ready;

  always_comb begin
    tag_qid_d  = tag_qid_q;
    tag_wptr_d = tag_wptr_q + OB_W'(rd_fire);
    tag_rptr_d = tag_rptr_q + OB_W'(tag_pop);
    tag_cnt_d  = tag_cnt_q + OC_W'(rd_fire) - OC_W'(tag_pop);
    if (rd_fire) begin
      tag_qid_d[tag_wptr_q] = rd_req_qid;
    end
    ret_data_d = ret_data_q;
    ret_qid_d  = ret_qid_q;
    ret_wptr_d = ret_wptr_q + OB_W'(ret_push);
    ret_rptr_d = ret_rptr_q + OB_W'(ret_pop);
    ret_cnt_d  = ret_cnt_q + OC_W'(ret_push) - OC_W'(ret_pop);
    if (ret_push) begin
      ret_data_d[ret_wptr_q] = mem_rd_data;
      ret_qid_d[ret_wptr_q]  = tag_qid_q[tag_rptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        wptr_q[i]  <= '0;
        rptr_q[i]  <= '0;
        count_q[i] <= '0;
      end
      q_empty_q     <= '1;
      q_afull_q     <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      tag_wptr_q    <= '0;
      tag_rptr_q    <= '0;
      tag_cnt_q     <= '0;
      ret_wptr_q    <= '0;
      ret_rptr_q    <= '0;
      ret_cnt_q     <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      q_empty_q     <= q_empty_d;
      q_afull_q     <= q_afull_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      tag_wptr_q    <= tag_wptr_d;
      tag_rptr_q    <= tag_rptr_d;
      tag_cnt_q     <= tag_cnt_d;
      ret_wptr_q    <= ret_wptr_d;
      ret_rptr_q    <= ret_rptr_d;
      ret_cnt_q     <= ret_cnt_d;
    end
  end

  // Storage arrays need no reset; their pointers define validity.
  always_ff @(posedge clk) begin
    tag_qid_q  <= tag_qid_d;
    ret_data_q <= ret_data_d;
    ret_qid_q  <= ret_qid_d;
  end

  assign q_empty     = q_empty_q;
  assign q_afull     = q_afull_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign rd_valid    = (ret_cnt_q != '0);
  assign rd_data     = rd_valid ? ret_data_q[ret_rptr_q] : '0;
  assign rd_qid      = rd_valid ? ret_qid_q[ret_rptr_q] : '0;

`ifdef SRAM_MQ_STATS_EN
  logic [CNT_W-1:0] hwm_q [NUM_QUEUES];
  logic [CNT_W-1:0] hwm_d [NUM_QUEUES];

  always_comb begin
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      hwm_d[i] = (count_q[i] > hwm_q[i]) ? count_q[i] : hwm_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
        hwm_q[i] <= '0;
      end
    end else begin
      hwm_q <= hwm_d;
    end
  end

  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_hwm
    assign stat_hwm[g*CNT_W +: CNT_W] = hwm_q[g];
  end
`else
  assign stat_hwm = '0;
`endif

  ret_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(ret_push && !ret_pop && (ret_cnt_q == OC_W'(MAX_OUTSTANDING))))
    else $error("return buffer overflow");

  tag_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(rd_fire && !tag_pop && (tag_cnt_q == OC_W'(MAX_OUTSTANDING))))
    else $error("tag fifo overflow");

endmodule

// File: tb/tb_sram_mq_fifo_ctrl.sv
// Directed bench for sram_mq_fifo_ctrl with 16-word queues and a half-cycle SRAM responder.
module tb_sram_mq_fifo_ctrl;
  localparam int DW = 16;
  localparam int NQ = 4;
  localparam int QW = 2;
  localparam int QB = 4;
  localparam int AW = 6;
  localparam int HW = QB + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [QW-1:0] wr_qid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req_valid;
  logic [QW-1:0] rd_req_qid;
  logic          rd_req_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [QW-1:0] rd_qid;
  logic          rd_ready;
  logic [NQ-1:0] q_empty;
  logic [NQ-1:0] q_afull;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_full;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_full;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_rd_valid = 1'b0;
  logic [NQ*HW-1:0] stat_hwm;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram [64];
  logic [DW-1:0] pend [$];
  logic          resp_hold = 1'b0;

  sram_mq_fifo_ctrl #(
    .DATA_WIDTH      (DW),
    .NUM_QUEUES      (NQ),
    .QID_WIDTH       (QW),
    .QDEPTH_BITS     (QB),
    .ADDR_WIDTH      (AW),
    .AFULL_MARGIN    (8),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_qid       (wr_qid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_req_valid (rd_req_valid),
    .rd_req_qid   (rd_req_qid),
    .rd_req_ready (rd_req_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_qid       (rd_qid),
    .rd_ready     (rd_ready),
    .q_empty      (q_empty),
    .q_afull      (q_afull),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_full  (mem_wr_full),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_full  (mem_rd_full),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .stat_hwm     (stat_hwm)
  );

  always #5 clk = ~clk;

  // SRAM model: responses come back in issue order, held back while resp_hold is set.
  always @(negedge clk) begin
    if (mem_wr_en) sram[mem_wr_addr] = mem_wr_data;
    if (mem_rd_en) pend.push_back(sram[mem_rd_addr]);
    if (!resp_hold && pend.size() > 0) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = pend.pop_front();
    end else begin
      mem_rd_valid = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int q, input int n, input int base, input int a0);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_qid   = QW'(q);
      wr_data  = DW'(base + i);
      #1 check_eq("wr_ready", 32'(wr_ready), 1);
      @(posedge clk); #1;
      check_eq("mem_wr_en", 32'(mem_wr_en), 1);
      check_eq("mem_wr_addr", 32'(mem_wr_addr), q * 16 + (a0 + i) % 16);
      check_eq("mem_wr_data", 32'(mem_wr_data), base + i);
      check_eq("q_empty_low", 32'(q_empty[q]), 0);
    end
    wr_valid = 1'b0;
  endtask

  task automatic read_burst(input int q, input int n, input int a0);
    for (int i = 0; i < n; i++) begin
      rd_req_valid = 1'b1;
      rd_req_qid   = QW'(q);
      #1 check_eq("rd_req_ready", 32'(rd_req_ready), 1);
      @(posedge clk); #1;
      check_eq("mem_rd_en", 32'(mem_rd_en), 1);
      check_eq("mem_rd_addr", 32'(mem_rd_addr), q * 16 + (a0 + i) % 16);
    end
    rd_req_valid = 1'b0;
  endtask

  task automatic pop_check(input int q, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      check_eq("rd_valid", 32'(rd_valid), 1);
      check_eq("rd_qid", 32'(rd_qid), q);
      check_eq("rd_data", 32'(rd_data), base + i);
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_qid = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_req_qid = '0; rd_ready = 1'b0;
    mem_wr_full = 1'b0; mem_rd_full = 1'b0;
    idle(3);
    check_eq("rst_q_empty", 32'(q_empty), 32'hF);
    check_eq("rst_q_afull", 32'(q_afull), 0);
    check_eq("rst_mem_wr_en", 32'(mem_wr_en), 0);
    check_eq("rst_mem_rd_en", 32'(mem_rd_en), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_mem_wr_addr", 32'(mem_wr_addr), 0);
    check_eq("rst_stat_hwm", 32'(stat_hwm), 0);
    reset = 1'b0;
    idle(1);

    // Basic write/read on q2
    push_words(2, 3, 'hA, 0);
    idle(1);
    check_eq("wr_idle", 32'(mem_wr_en), 0);
    read_burst(2, 3, 0);
    idle(3);
    pop_check(2, 3, 'hA);
    check_eq("q2_drained_rd_valid", 32'(rd_valid), 0);
    check_eq("q2_empty", 32'(q_empty[2]), 1);

    // Fill q1, almost-full threshold and full stall
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1; wr_qid = 2'd1; wr_data = DW'('h100 + i);
      #1 check_eq("fill_wr_ready", 32'(wr_ready), 1);
      @(posedge clk); #1;
      check_eq("fill_addr", 32'(mem_wr_addr), 16 + i);
      check_eq("fill_afull", 32'(q_afull[1]), (i >= 7) ? 1 : 0);
    end
    #1 check_eq("full_wr_ready", 32'(wr_ready), 0);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    read_burst(1, 16, 0);
    idle(4);
    rd_ready = 1'b0;
    check_eq("drain_rd_valid", 32'(rd_valid), 0);
    check_eq("drain_q_empty", 32'(q_empty[1]), 1);
    check_eq("drain_q_afull", 32'(q_afull[1]), 0);
    push_words(1, 4, 'h180, 0);
    read_burst(1, 4, 0);
    idle(3);
    pop_check(1, 4, 'h180);

    // Same-cycle write and read on q0 at count 5
    push_words(0, 5, 'h200, 0);
    idle(1);
    wr_valid = 1'b1; wr_qid = 2'd0; wr_data = 16'h205;
    rd_req_valid = 1'b1; rd_req_qid = 2'd0;
    #1;
    check_eq("same_wr_ready", 32'(wr_ready), 1);
    check_eq("same_rd_req_ready", 32'(rd_req_ready), 1);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    check_eq("same_mem_wr_en", 32'(mem_wr_en), 1);
    check_eq("same_mem_rd_en", 32'(mem_rd_en), 1);
    check_eq("same_wr_addr", 32'(mem_wr_addr), 5);
    check_eq("same_rd_addr", 32'(mem_rd_addr), 0);
    read_burst(0, 5, 1);
    rd_req_valid = 1'b1; rd_req_qid = 2'd0;
    #1 check_eq("same_count_zero", 32'(rd_req_ready), 0);
    rd_req_valid = 1'b0;
    check_eq("same_q_empty", 32'(q_empty[0]), 1);
    idle(3);
    pop_check(0, 6, 'h200);

    // Credit limit on q3
    push_words(3, 10, 'h300, 0);
    idle(1);
    read_burst(3, 8, 0);
    rd_req_valid = 1'b1; rd_req_qid = 2'd3;
    #1 check_eq("credit_block", 32'(rd_req_ready), 0);
    idle(3);
    check_eq("credit_block_held", 32'(rd_req_ready), 0);
    check_eq("credit_rd_data", 32'(rd_data), 'h300);
    rd_ready = 1'b1;
    #1 check_eq("credit_release", 32'(rd_req_ready), 1);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    check_eq("credit_9th_rd_en", 32'(mem_rd_en), 1);
    check_eq("credit_9th_addr", 32'(mem_rd_addr), 'h38);
    #1 check_eq("credit_reblock", 32'(rd_req_ready), 0);
    rd_req_valid = 1'b0;
    idle(3);
    pop_check(3, 8, 'h301);
    read_burst(3, 1, 9);
    idle(3);
    pop_check(3, 1, 'h309);
    push_words(3, 2, 'h3A0, 10);
    idle(2);
`ifdef SRAM_MQ_STATS_EN
    check_eq("stat_hwm_q3", 32'(stat_hwm[3*HW +: HW]), 10);
`else
    check_eq("stat_hwm_q3", 32'(stat_hwm[3*HW +: HW]), 0);
`endif

    // Write path backpressure
    mem_wr_full = 1'b1;
    wr_valid = 1'b1; wr_qid = 2'd0; wr_data = 16'hBAD;
    #1 check_eq("wr_full_ready", 32'(wr_ready), 0);
    @(posedge clk); #1;
    check_eq("wr_full_no_en", 32'(mem_wr_en), 0);
    wr_valid = 1'b0; mem_wr_full = 1'b0;

    // Reset with three reads in flight, then stale responses
    push_words(2, 3, 'hD0, 3);
    resp_hold = 1'b1;
    read_burst(2, 3, 3);
    idle(2);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    resp_hold = 1'b0;
    idle(6);
    check_eq("stale_rd_valid", 32'(rd_valid), 0);
    check_eq("stale_q_empty", 32'(q_empty), 32'hF);
    rd_req_valid = 1'b1; rd_req_qid = 2'd2;
    #1 check_eq("stale_rd_req_ready", 32'(rd_req_ready), 0);
    rd_req_valid = 1'b0;
    idle(1);
    push_words(0, 1, 'hEE, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_mq_fifo_ctrl.md
Name: sram_mq_fifo_ctrl

Overview:
- Parametrised multi-queue FIFO controller that maps NUM_QUEUES independent circular queues onto one external SRAM word space.
- Sits between the AXI-side queue mux/demux and the SRAM interface, taking over the arbitration role of the existing r_w_ctrl.
- Generalises queue count, depth and data width.
- Adds correct wrap-around, same-cycle read/write on one queue, almost-full thresholds, credit-limited outstanding reads, and an in-order return buffer with queue tags.

Parameters:
- DATA_WIDTH, 265: width of one stored word (data + tkeep/tlast packing).
- NUM_QUEUES, 4: number of logical queues.
- QID_WIDTH, 2: clog2(NUM_QUEUES), minimum 1.
- QDEPTH_BITS, 17: log2 of words per queue.
- ADDR_WIDTH, 19: must equal QID_WIDTH+QDEPTH_BITS. Checked at elaboration with $error.
- AFULL_MARGIN, 8: q_afull asserts when free words <= AFULL_MARGIN.
- MAX_OUTSTANDING, 8: return-buffer depth, power of 2. Also the read credit limit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write word offered
- wr_qid  in  QID_WIDTH  target queue
- wr_data  in  DATA_WIDTH  word
- wr_ready  out  1  write accepted when wr_valid&&wr_ready
- rd_req_valid  in  1  read request offered
- rd_req_qid  in  QID_WIDTH  queue to pop
- rd_req_ready  out  1  request accepted when rd_req_valid&&rd_req_ready
- rd_valid  out  1  returned word available
- rd_data  out  DATA_WIDTH  returned word
- rd_qid  out  QID_WIDTH  queue the word came from
- rd_ready  in  1  consumer takes rd_data
- q_empty  out  NUM_QUEUES  per-queue empty (registered)
- q_afull  out  NUM_QUEUES  per-queue almost-full (registered)
- mem_wr_en  out  1  SRAM write strobe
- mem_wr_addr  out  ADDR_WIDTH  write address
- mem_wr_data  out  DATA_WIDTH  write data
- mem_wr_full  in  1  SRAM write path cannot accept
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_rd_full  in  1  SRAM read path cannot accept
- mem_rd_data  in  DATA_WIDTH  read response data
- mem_rd_valid  in  1  read response strobe; responses return in issue order
- stat_hwm  out  NUM_QUEUES*(QDEPTH_BITS+1)  per-queue high-water mark (optional feature)

Behaviour:
- Reset values:
  - All wptr/rptr = 0; all counts = 0.
  - q_empty all 1; q_afull all 0.
  - mem_wr_en, mem_rd_en, rd_valid = 0; addresses and data = 0.
  - Tag FIFO and return buffer flushed; outstanding = 0; stat_hwm = 0.
- Per-queue state:
  - wptr, rptr: QDEPTH_BITS each, wrap modulo 2^QDEPTH_BITS.
  - count: QDEPTH_BITS+1 bits, range 0..2^QDEPTH_BITS.
- Address is {qid, ptr}.
- Write path:
  - wr_ready = !mem_wr_full && count[wr_qid] != 2^QDEPTH_BITS. Combinational in wr_qid; wr_valid must not depend on wr_ready.
  - On accept at cycle t: mem_wr_en=1 at t+1 with addr {wr_qid, wptr} and data registered; wptr increments.
- Read path:
  - rd_req_ready = !mem_rd_full && count[rd_req_qid] != 0 && credits_used < MAX_OUTSTANDING.
  - credits_used = issued-not-returned + words held in the return buffer.
  - On accept at t: mem_rd_en=1 at t+1 with addr {qid, rptr}; rptr increments; qid pushed to the tag FIFO.
- Count update:
  - Write only: +1. Read only: -1.
  - Write and read on the same queue in the same cycle: unchanged.
  - Write and read on different queues: each updated independently.
- Flags:
  - q_empty[i] = (next_count==0), q_afull[i] = (2^QDEPTH_BITS - next_count <= AFULL_MARGIN), both registered from next_count.
  - A write accepted at t makes the queue readable from t+1. Its mem_wr_en (t+1) always precedes the dependent mem_rd_en (>= t+2).
- Return path:
  - mem_rd_valid pops the tag FIFO; {tag, mem_rd_data} is pushed into the return buffer.
  - rd_valid = buffer non-empty; first-word fall-through.
  - Pop on rd_valid&&rd_ready; the credit is released in the same cycle.
- Boundaries:
  - Wrap from ptr 2^QDEPTH_BITS-1 to 0 stays inside the queue's own region.
  - mem_rd_valid while outstanding==0 (stale response after reset) is dropped without any state change.
  - Buffer overflow cannot occur by construction; add a simulation assertion for it.
- Reset mid-operation discards all in-flight reads and queue contents.

Optional Feature:
- Macro SRAM_MQ_STATS_EN.
- Defined: stat_hwm[i] holds the maximum count[i] reached since reset, updated one cycle after count.
- Undefined: stat_hwm is tied to 0 and no tracking registers are built.

Test Plan:
- Reset, then write 3 words to q2 (data 0xA,0xB,0xC) -> mem_wr_addr = {2,0},{2,1},{2,2}. q_empty[2] falls the cycle after the first accept. Reading 3 from q2 returns 0xA,0xB,0xC with rd_qid=2.
- QDEPTH_BITS=4: fill q1 with 16 words -> q_afull[1] rises at count 8 (AFULL_MARGIN=8), wr_ready=0 at count 16. Drain 16, refill 4 -> mem_wr_addr wraps {1,15} -> {1,0}.
- Same-cycle write and read to q0 at count 5 -> count stays 5; both mem_wr_en and mem_rd_en pulse next cycle.
- rd_ready held 0 with MAX_OUTSTANDING=8: after 8 accepted requests rd_req_ready=0. One rd_ready pop re-enables it in the same cycle.
- mem_wr_full=1 -> wr_ready=0 and no mem_wr_en. Assert reset with 3 reads outstanding, then inject 3 late mem_rd_valid -> rd_valid stays 0 and q_empty is all 1.
- With SRAM_MQ_STATS_EN: write 10, read 10, write 2 on q3 -> stat_hwm[3]=10.
